// File: rtl/unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_ctrl
// Purpose  : Single-port unified 32-bit word memory shared by the instruction
//            fetch port and the data port. A fixed-priority arbiter (data
//            first) grants one access at a time. The access runs through a
//            programmable number of wait cycles before completing with a
//            one-cycle ready pulse on the granted port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_W   word-address bits, depth = 2**ADDR_W words (ADDR_W <= 29)
//   LATENCY  wait cycles between grant and completion (0..15)
// Ports
//   clk, reset        clock, synchronous active-high reset
//   i_req/i_addr      fetch request (held until i_ready) and byte address
//   i_rdata/i_ready   fetched word and one-cycle completion pulse
//   d_req/d_we/d_be   data request, write select, per-byte write enables
//   d_addr/d_wdata    data byte address and write data
//   d_rdata/d_ready   read word and one-cycle completion pulse
//   d_err             misaligned data access flag (MISALIGN_CHK_EN only)
// Optional feature
//   Define MISALIGN_CHK_EN to add d_err. A data access with d_addr[1:0]!=0
//   then completes with d_err=1, d_rdata=0 and no write to the array.
// ============================================================================
module unified_mem_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
`ifdef MISALIGN_CHK_EN
    output logic        d_ready,
    output logic        d_err
`else
    output logic        d_ready
`endif
);

    localparam int         c_DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] c_LAT   = 4'(LATENCY);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [3:0]        r_cnt;

    // Access context captured at grant; the requester may change or drop its
    // inputs afterwards without affecting the access in flight.
    logic              r_gnt_d;
    logic              r_we;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_wdata;
    logic              r_mis;

    logic [31:0]       r_mem [c_DEPTH];

    logic              w_grant_d;
    logic              w_grant_i;
    logic              w_mis;
    logic              w_done;
    logic [31:0]       w_rword;

    // Address bits outside the word index are intentionally discarded.
    logic              w_unused;
    assign w_unused = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                        d_addr[31:ADDR_W+2], d_addr[1:0]};

    assign w_grant_d = (r_state == c_IDLE) && d_req;
    assign w_grant_i = (r_state == c_IDLE) && !d_req && i_req;

`ifdef MISALIGN_CHK_EN
    assign w_mis = (d_addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    assign w_done  = (r_state == c_DONE);
    assign w_rword = r_mem[r_idx];

    // ------------------------------------------------------------------
    // State register and captured access context
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_gnt_d <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_d) begin
                        r_gnt_d <= 1'b1;
                        r_we    <= d_we;
                        r_be    <= d_be;
                        r_idx   <= d_addr[ADDR_W+1:2];
                        r_wdata <= d_wdata;
                        r_mis   <= w_mis;
                        r_cnt   <= c_LAT;
                    end else if (w_grant_i) begin
                        r_gnt_d <= 1'b0;
                        r_we    <= 1'b0;
                        r_be    <= 4'd0;
                        r_idx   <= i_addr[ADDR_W+1:2];
                        r_mis   <= 1'b0;
                        r_cnt   <= c_LAT;
                    end
                end
                c_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. WAIT exits when the counter is already zero at the
    // start of the cycle, so WAIT lasts LATENCY+1 cycles and ready lands
    // LATENCY+2 cycles after the request is seen in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (d_req || i_req) begin
                    w_next = c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = c_DONE;
                end
            end
            c_DONE: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Port outputs: only live during DONE; read data comes straight from the
    // array at the captured index, so no extra output register is needed.
    // ------------------------------------------------------------------
    always_comb begin
        i_ready = 1'b0;
        d_ready = 1'b0;
        i_rdata = 32'd0;
        d_rdata = 32'd0;
        if (w_done) begin
            if (r_gnt_d) begin
                d_ready = 1'b1;
                if (!r_we && !r_mis) begin
                    d_rdata = w_rword;
                end
            end else begin
                i_ready = 1'b1;
                i_rdata = w_rword;
            end
        end
    end

`ifdef MISALIGN_CHK_EN
    assign d_err = w_done && r_gnt_d && r_mis;
`endif

    // ------------------------------------------------------------------
    // Array write at the edge that ends DONE. A reset on that same edge
    // abandons the access, so the write is gated by reset as well.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && w_done && r_gnt_d && r_we && !r_mis) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_ctrl
// Purpose  : Self-checking bench for unified_mem_ctrl. Directed scenarios
//            followed by randomized traffic checked against a word-array
//            reference model with spec-level latency and byte-merge rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_ctrl;

    localparam int AW    = 10;
    localparam int LAT   = 1;
    localparam int DEPTH = 1 << AW;
    localparam int EXP_L = LAT + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = 4'd0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ready;
`ifdef MISALIGN_CHK_EN
    logic        d_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    unified_mem_ctrl #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_ready (i_ready),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_be    (d_be),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
`ifdef MISALIGN_CHK_EN
        .d_ready (d_ready),
        .d_err   (d_err)
`else
        .d_ready (d_ready)
`endif
    );

    function automatic logic cur_err();
`ifdef MISALIGN_CHK_EN
        return d_err;
`else
        return 1'b0;
`endif
    endfunction

    // One data transaction. lat = cycles from request cycle to ready (-1 on
    // timeout); after = d_ready one cycle after the pulse.
    task automatic data_xfer(input logic we, input logic [3:0] be,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input bit drop, input bit scramble,
                             output int lat, output logic [31:0] rdata,
                             output logic err, output logic other,
                             output logic after);
        lat = -1; rdata = 32'd0; err = 1'b0; other = 1'b0; after = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (d_ready) begin
                lat = n; rdata = d_rdata; err = cur_err(); other = i_ready;
                break;
            end
            if (n == 0) begin
                @(posedge clk); #1;
                if (drop) d_req = 1'b0;
                if (scramble) begin
                    d_we = 1'($urandom); d_be = 4'($urandom);
                    d_addr = $urandom; d_wdata = $urandom;
                end
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        after = d_ready;
    endtask

    task automatic fetch_xfer(input logic [31:0] addr, input bit drop,
                              input bit scramble, output int lat,
                              output logic [31:0] rdata, output logic other,
                              output logic after);
        lat = -1; rdata = 32'd0; other = 1'b0; after = 1'b0;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = addr;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (i_ready) begin
                lat = n; rdata = i_rdata; other = d_ready;
                break;
            end
            if (n == 0) begin
                @(posedge clk); #1;
                if (drop) i_req = 1'b0;
                if (scramble) i_addr = $urandom;
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        after = i_ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({i_ready, d_ready} !== 2'b00) begin
            bad++; $display("FAIL reset_ready: got %b want 00", {i_ready, d_ready});
        end
        total++;
        if (i_rdata !== 32'd0) begin
            bad++; $display("FAIL reset_i_rdata: got %h want 0", i_rdata);
        end
        total++;
        if (d_rdata !== 32'd0) begin
            bad++; $display("FAIL reset_d_rdata: got %h want 0", d_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic e, o, a;
        data_xfer(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0, lat, rd, e, o, a);
        total++;
        if (lat != EXP_L) begin
            bad++; $display("FAIL wr_latency: got %0d want %0d", lat, EXP_L);
        end
        total++;
        if (a !== 1'b0) begin
            bad++; $display("FAIL wr_pulse_width: got %b want 0", a);
        end
        data_xfer(1'b0, 4'h0, 32'h10, 32'h0, 0, 0, lat, rd, e, o, a);
        total++;
        if (lat != EXP_L) begin
            bad++; $display("FAIL rd_latency: got %0d want %0d", lat, EXP_L);
        end
        total++;
        if (rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_data: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_byte_enable();
        int lat; logic [31:0] rd; logic e, o, a;
        data_xfer(1'b1, 4'hF, 32'h20, 32'h11223344, 0, 0, lat, rd, e, o, a);
        data_xfer(1'b1, 4'h5, 32'h20, 32'hAABBCCDD, 0, 0, lat, rd, e, o, a);
        data_xfer(1'b0, 4'h0, 32'h20, 32'h0, 0, 0, lat, rd, e, o, a);
        total++;
        if (rd !== 32'h11BB33DD) begin
            bad++; $display("FAIL be_merge: got %h want 11bb33dd", rd);
        end
        data_xfer(1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, 0, 0, lat, rd, e, o, a);
        total++;
        if (lat != EXP_L) begin
            bad++; $display("FAIL be_zero_latency: got %0d want %0d", lat, EXP_L);
        end
        data_xfer(1'b0, 4'h0, 32'h20, 32'h0, 0, 0, lat, rd, e, o, a);
        total++;
        if (rd !== 32'h11BB33DD) begin
            bad++; $display("FAIL be_zero_nowrite: got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] rd; logic e, o, a;
        data_xfer(1'b1, 4'hF, 32'h1004, 32'h5A5A5A5A, 0, 0, lat, rd, e, o, a);
        data_xfer(1'b0, 4'h0, 32'h0004, 32'h0, 0, 0, lat, rd, e, o, a);
        total++;
        if (rd !== 32'h5A5A5A5A) begin
            bad++; $display("FAIL wrap: got %h want 5a5a5a5a", rd);
        end
    endtask

    task automatic test_simultaneous();
        int lat; logic [31:0] rd; logic e, o, a;
        int dl, il;
        logic [31:0] drd, ird;
        data_xfer(1'b1, 4'hF, 32'h80, 32'hCAFEF00D, 0, 0, lat, rd, e, o, a);
        dl = -1; il = -1; drd = 32'd0; ird = 32'd0;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h20;
        i_req = 1'b1; i_addr = 32'h83;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (d_ready && dl < 0) begin dl = n; drd = d_rdata; end
            if (i_ready && il < 0) begin il = n; ird = i_rdata; end
            @(posedge clk); #1;
            if (dl >= 0) d_req = 1'b0;
            if (il >= 0) begin i_req = 1'b0; break; end
        end
        d_req = 1'b0; i_req = 1'b0;
        total++;
        if (dl != EXP_L) begin
            bad++; $display("FAIL sim_d_latency: got %0d want %0d", dl, EXP_L);
        end
        total++;
        if (il != 2 * LAT + 5) begin
            bad++; $display("FAIL sim_i_latency: got %0d want %0d", il, 2 * LAT + 5);
        end
        total++;
        if (drd !== 32'h11BB33DD) begin
            bad++; $display("FAIL sim_d_data: got %h want 11bb33dd", drd);
        end
        total++;
        if (ird !== 32'hCAFEF00D) begin
            bad++; $display("FAIL sim_i_data: got %h want cafef00d", ird);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic e, o, a;
        logic seen;
        data_xfer(1'b1, 4'hF, 32'h30, 32'h0, 0, 0, lat, rd, e, o, a);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h30; d_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        total++;
        if ({d_ready, d_rdata} !== 33'd0) begin
            bad++; $display("FAIL rstmid_outputs: got %b/%h want 0/0", d_ready, d_rdata);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | d_ready | i_ready;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL rstmid_no_ready: got %b want 0", seen);
        end
        data_xfer(1'b0, 4'h0, 32'h30, 32'h0, 0, 0, lat, rd, e, o, a);
        total++;
        if (rd !== 32'h0) begin
            bad++; $display("FAIL rstmid_no_write: got %h want 0", rd);
        end
    endtask

`ifdef MISALIGN_CHK_EN
    task automatic test_misalign();
        int lat; logic [31:0] rd; logic e, o, a;
        data_xfer(1'b1, 4'hF, 32'h40, 32'h12345678, 0, 0, lat, rd, e, o, a);
        data_xfer(1'b1, 4'hF, 32'h42, 32'hFFFFFFFF, 0, 0, lat, rd, e, o, a);
        total++;
        if (e !== 1'b1 || lat != EXP_L) begin
            bad++; $display("FAIL mis_err: got err=%b lat=%0d want err=1 lat=%0d", e, lat, EXP_L);
        end
        data_xfer(1'b0, 4'h0, 32'h40, 32'h0, 0, 0, lat, rd, e, o, a);
        total++;
        if (rd !== 32'h12345678 || e !== 1'b0) begin
            bad++; $display("FAIL mis_nowrite: got %h err=%b want 12345678 err=0", rd, e);
        end
    endtask
`endif

    task automatic test_random();
        int lat; logic [31:0] rd; logic e, o, a;
        int kind, idx;
        logic [31:0] addr, wd, exp_rd;
        logic [3:0] be;
        logic [1:0] low;
        logic mis;
        bit drop, scr;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model_mem[i] = wd;
            data_xfer(1'b1, 4'hF, 32'(i * 4), wd, 0, 0, lat, rd, e, o, a);
        end
        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 2);
            idx  = $urandom_range(0, 15);
            low  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            addr = ($urandom & 32'hFFFFF000) | 32'(idx * 4) | 32'(low);
            drop = ($urandom_range(0, 3) == 0);
            scr  = ($urandom_range(0, 3) == 0);
`ifdef MISALIGN_CHK_EN
            mis = (low != 2'd0);
`else
            mis = 1'b0;
`endif
            if (kind == 0) begin
                fetch_xfer(addr, drop, scr, lat, rd, o, a);
                exp_rd = model_mem[idx];
            end else if (kind == 1) begin
                data_xfer(1'b0, 4'($urandom), addr, $urandom, drop, scr, lat, rd, e, o, a);
                exp_rd = mis ? 32'd0 : model_mem[idx];
            end else begin
                wd = $urandom;
                be = 4'($urandom);
                data_xfer(1'b1, be, addr, wd, drop, scr, lat, rd, e, o, a);
                if (!mis) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end
                exp_rd = 32'd0;
            end
            total++;
            if (lat != EXP_L) begin
                bad++; $display("FAIL rnd_latency t=%0d: got %0d want %0d", t, lat, EXP_L);
            end
            total++;
            if (rd !== exp_rd) begin
                bad++; $display("FAIL rnd_rdata t=%0d kind=%0d: got %h want %h", t, kind, rd, exp_rd);
            end
            total++;
            if (o !== 1'b0 || a !== 1'b0) begin
                bad++; $display("FAIL rnd_ready_shape t=%0d: got other=%b after=%b want 0 0", t, o, a);
            end
`ifdef MISALIGN_CHK_EN
            if (kind != 0) begin
                total++;
                if (e !== mis) begin
                    bad++; $display("FAIL rnd_err t=%0d: got %b want %b", t, e, mis);
                end
            end
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
`ifdef MISALIGN_CHK_EN
        test_misalign();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
